// File: rtl/bfly10_if.sv
// Streaming bus for the module-1 first butterfly: 16-lane complex input with a
// frame-valid strobe, and a tagged 16-lane complex output.
interface bfly10_if #(
  parameter int unsigned IN_W     = 11,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned NCHAN    = 16,
  parameter int unsigned HALF_CYC = 16
);
  localparam int unsigned CntW = $clog2(HALF_CYC);

  logic                    valid_in;
  logic signed [IN_W-1:0]  data_re_in  [NCHAN];
  logic signed [IN_W-1:0]  data_im_in  [NCHAN];
  logic                    valid_out;
  logic signed [OUT_W-1:0] data_re_out [NCHAN];
  logic signed [OUT_W-1:0] data_im_out [NCHAN];
  logic                    out_half;
  logic [CntW-1:0]         out_cnt;
  logic                    frame_err;

  // Producer / consumer side that drives the input stream and observes results.
  modport master (
    output valid_in, data_re_in, data_im_in,
    input  valid_out, data_re_out, data_im_out, out_half, out_cnt, frame_err
  );

  // Butterfly side.
  modport slave (
    input  valid_in, data_re_in, data_im_in,
    output valid_out, data_re_out, data_im_out, out_half, out_cnt, frame_err
  );
endinterface

// File: rtl/bfly10_stage.sv
// Radix-2 DIF butterfly pairing sample n with n+HALF_CYC*NCHAN of each frame.
// Sums stream out during the second input half; differences are parked in the
// buffer and drained in the following HALF_CYC cycles.
module bfly10_stage #(
  parameter int unsigned IN_W     = 11,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned NCHAN    = 16,
  parameter int unsigned HALF_CYC = 16
) (
  input logic     clk,
  input logic     rstn,
  bfly10_if.slave bus
);
  localparam int unsigned CntW = $clog2(HALF_CYC);
  localparam logic [CntW:0]   LastIn    = (CntW+1)'(2 * HALF_CYC - 1);
  localparam logic [CntW-1:0] LastDrain = CntW'(HALF_CYC - 1);

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return {{(OUT_W - IN_W){x[IN_W-1]}}, x};
  endfunction

  // Input capture stage (gives the 17-cycle first-output latency).
  logic                    in_vld_q;
  logic signed [IN_W-1:0]  in_re_q [NCHAN];
  logic signed [IN_W-1:0]  in_im_q [NCHAN];

  logic [CntW:0]           in_cnt_q, in_cnt_d;
  logic                    drain_act_q, drain_act_d;
  logic [CntW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                    err_q, err_d;

  logic signed [OUT_W-1:0] mem_re_q [HALF_CYC][NCHAN];
  logic signed [OUT_W-1:0] mem_im_q [HALF_CYC][NCHAN];
  logic signed [OUT_W-1:0] wr_re [NCHAN];
  logic signed [OUT_W-1:0] wr_im [NCHAN];
  logic                    wr_en;

  logic                    valid_q, valid_d;
  logic                    half_q, half_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [OUT_W-1:0] out_re_q [NCHAN];
  logic signed [OUT_W-1:0] out_im_q [NCHAN];
  logic signed [OUT_W-1:0] out_re_d [NCHAN];
  logic signed [OUT_W-1:0] out_im_d [NCHAN];

  logic [CntW-1:0]         j;
  logic                    in_sum;

  assign j      = in_cnt_q[CntW-1:0];
  assign in_sum = in_cnt_q[CntW];

  // Register the incoming lanes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_vld_q <= 1'b0;
      for (int k = 0; k < NCHAN; k++) begin
        in_re_q[k] <= '0;
        in_im_q[k] <= '0;
      end
    end else begin
      in_vld_q <= bus.valid_in;
      in_re_q  <= bus.data_re_in;
      in_im_q  <= bus.data_im_in;
    end
  end

  // Frame counter, drain control, sticky error and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_q    <= '0;
      drain_act_q <= 1'b0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      half_q      <= 1'b0;
      cnt_q       <= '0;
      for (int k = 0; k < NCHAN; k++) begin
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      in_cnt_q    <= in_cnt_d;
      drain_act_q <= drain_act_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Half-frame buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NCHAN; k++) begin
        mem_re_q[j][k] <= wr_re[k];
        mem_im_q[j][k] <= wr_im[k];
      end
    end
  end

  // Next-state: counting, abort detection, drain sequencing, output select.
  always_comb begin
    in_cnt_d    = in_vld_q ? in_cnt_q + 1'b1 : '0;
    // A missing sample mid-frame truncates it; counter restarts at 0.
    err_d       = err_q | (!in_vld_q && (in_cnt_q != '0));
    drain_act_d = drain_act_q;
    drain_cnt_d = drain_cnt_q;
    wr_en       = in_vld_q;
    valid_d     = 1'b0;
    half_d      = half_q;
    cnt_d       = cnt_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    for (int k = 0; k < NCHAN; k++) begin
      wr_re[k] = in_sum ? mem_re_q[j][k] - sext(in_re_q[k]) : sext(in_re_q[k]);
      wr_im[k] = in_sum ? mem_im_q[j][k] - sext(in_im_q[k]) : sext(in_im_q[k]);
    end

    if (drain_act_q) begin
      drain_cnt_d = drain_cnt_q + 1'b1;
      if (drain_cnt_q == LastDrain) drain_act_d = 1'b0;
    end
    if (in_vld_q && (in_cnt_q == LastIn)) begin
      drain_act_d = 1'b1;
      drain_cnt_d = '0;
    end

    // Drain reads the pre-write contents, so an overlapping FILL is safe.
    if (drain_act_q) begin
      valid_d  = 1'b1;
      half_d   = 1'b1;
      cnt_d    = drain_cnt_q;
      out_re_d = mem_re_q[drain_cnt_q];
      out_im_d = mem_im_q[drain_cnt_q];
    end else if (in_vld_q && in_sum) begin
      valid_d = 1'b1;
      half_d  = 1'b0;
      cnt_d   = j;
      for (int k = 0; k < NCHAN; k++) begin
        out_re_d[k] = mem_re_q[j][k] + sext(in_re_q[k]);
        out_im_d[k] = mem_im_q[j][k] + sext(in_im_q[k]);
      end
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.out_half    = half_q;
  assign bus.out_cnt     = cnt_q;
  assign bus.data_re_out = out_re_q;
  assign bus.data_im_out = out_im_q;
  assign bus.frame_err   = err_q;
endmodule

// File: doc/bfly10_stage.md
# bfly10_stage

First radix-2 DIF butterfly of module 1. It consumes the 16-lane <5.6> stream produced by the module-0 CBFP normalizer and pairs sample n with sample n+256 of each 512-point frame. Sums are emitted first, then differences, as one contiguous 32-cycle burst. The downstream twiddle stage takes the `out_half`/`out_cnt` tags to select twiddle factors for the difference half.

## Interface
- IN_W, 11: input sample width, signed <5.6>
- OUT_W, 12: output width, signed <6.6>; must be ≥ IN_W+1
- NCHAN, 16: lanes per cycle
- HALF_CYC, 16: cycles per half-frame (frame = 2·HALF_CYC·NCHAN = 512 points)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- valid_in  in  1  high for exactly 2·HALF_CYC contiguous cycles per frame
- data_re_in  in  [NCHAN] × IN_W signed  real lanes
- data_im_in  in  [NCHAN] × IN_W signed  imaginary lanes
- valid_out  out  1  output data valid
- data_re_out  out  [NCHAN] × OUT_W signed  real result
- data_im_out  out  [NCHAN] × OUT_W signed  imaginary result
- out_half  out  1  0 = sum half, 1 = difference half
- out_cnt  out  $clog2(HALF_CYC)  index of current output cycle within its half
- frame_err  out  1  sticky flag: a frame was truncated

## Operation
- Storage: one buffer of HALF_CYC entries × NCHAN lanes × (re, im) × OUT_W bits.
- Input counter `in_cnt` (0..2·HALF_CYC-1) advances on each valid_in cycle.
- Let j = in_cnt mod HALF_CYC.
- FILL (in_cnt 0..15):
  - Write sign-extended input (a) to buffer[j].
  - Before the write, read buffer[j]. If a drain is active, emit that entry as difference j (read-before-write in the same cycle).
- SUM (in_cnt 16..31), with input b:
  - Emit a+b, where a = buffer[j].
  - Write a−b back into buffer[j].
  - At in_cnt=31 arm the drain: `drain_cnt`=0, drain active.
- DRAIN (16 cycles after SUM):
  - Emit buffer[drain_cnt] as a difference, `drain_cnt`++.
  - DRAIN runs regardless of valid_in, so a back-to-back frame can FILL concurrently.
  - The drain ends after `drain_cnt`=15.
- Arithmetic:
  - Sign-extend operands to OUT_W before add/sub. No rounding, no saturation.
  - Range: sums −2048..2046, differences −2047..2047.
- Abort: if valid_in is low while in_cnt ∈ 1..31:
  - `in_cnt`←0 and set frame_err.
  - Emit no further sums for that frame and do not arm its drain.
  - A drain already active from the previous frame completes unaffected. Entries not yet overwritten still hold valid differences.
- frame_err clears only on reset.
- Idle gaps of any length between complete frames are legal.

## Timing
- All outputs are registered.
- Let t=0 be the clock edge where the first valid_in sample of a frame is captured.
- Sums: valid_out=1, out_half=0, out_cnt=0..15 at t=17..32.
- Differences: out_half=1, out_cnt=0..15 at t=33..48.
- Latency from first input to first output is 17 cycles. Each frame produces 32 contiguous valid_out cycles.
- Back-to-back frames (next frame starts at t=32):
  - valid_out stays high continuously.
  - The next frame's sums start at t=49.
- Reset values: valid_out=0, data_*_out=0, out_half=0, out_cnt=0, frame_err=0; `in_cnt` and drain state cleared; buffer contents don't-care.
- Reset mid-frame or mid-drain drops all pending output. After rstn rises, the next valid_in starts a fresh frame at in_cnt=0.
- When valid_out=0, data_*_out holds its last value (no glitch requirement beyond this).

## Test plan
- Single frame:
  - Stimulus: lane k of input cycle c = (re=c, im=−k) for c<16; (re=1, im=k) for c≥16.
  - Required: sums re=c'+1, im=0 at t=17..32; differences re=c'−1, im=−2k at t=33..48. Here c' = output index.
- Back-to-back frames A, B (A all re=+5, B all re=−3, im=0):
  - valid_out high t=17..80 with no gap.
  - A sums 10, A differences 0, B sums −6, B differences 0.
  - Confirms read-before-write during the overlapped FILL/DRAIN.
- Extremes:
  - a=−1024, b=−1024 → sum −2048.
  - a=1023, b=−1024 → sum −1, difference 2047.
  - a=−1024, b=1023 → difference −2047.
  - All exact in 12 bits.
- Abort:
  - Frame A completes; frame B drops valid_in at its cycle 20.
  - Required: A's differences complete; B's sums for cycles 16..19 are emitted, then valid_out drops; frame_err=1 and stays set.
  - A following full frame C is processed normally.
- Reset mid-frame:
  - rstn low at t=25 of a frame.
  - Required: all outputs go to 0 immediately.
  - A new frame after release produces its first valid_out exactly 17 cycles after its first sample; frame_err=0.
- Idle gaps: two frames separated by 7 idle cycles produce two independent 32-cycle bursts with correct results and no spurious valid_out between them.
